// File: rtl/convolution_processor_param.sv
// convolution_processor_param: full linear convolution Z[k] = sum_i X[i]*Y[k-i] over external 1-cycle-latency RAMs.
//   clk, rstn (async active-low), start (level request, honoured in IDLE only)
//   signed_mode, sizeX, sizeY: latched at start; dataX/dataY: RAM read data
//   memX_addr/memY_addr: registered read addresses; memZ_addr/dataZ/writeZ: result write port
//   busy: computation running; done: one-cycle completion pulse; err: qualifies done, 1 = rejected request
module convolution_processor_param #(
  parameter int DATA_WIDTH_DATA      = 8,
  parameter int DATA_WIDTH_MEMX_ADDR = 5,
  parameter int DATA_WIDTH_MEMY_ADDR = 5,
  parameter int DATA_WIDTH_MEMZ_ADDR = 6,
  parameter int DATA_WIDTH_DATAZ     = 16,
  parameter int SATURATE             = 0
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic                              signed_mode,
  input  logic [DATA_WIDTH_MEMX_ADDR:0]     sizeX,
  input  logic [DATA_WIDTH_MEMY_ADDR:0]     sizeY,
  input  logic [DATA_WIDTH_DATA-1:0]        dataX,
  input  logic [DATA_WIDTH_DATA-1:0]        dataY,
  output logic [DATA_WIDTH_MEMX_ADDR-1:0]   memX_addr,
  output logic [DATA_WIDTH_MEMY_ADDR-1:0]   memY_addr,
  output logic [DATA_WIDTH_MEMZ_ADDR-1:0]   memZ_addr,
  output logic [DATA_WIDTH_DATAZ-1:0]       dataZ,
  output logic                              writeZ,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);
  localparam int DW = DATA_WIDTH_DATA;
  localparam int MX = DATA_WIDTH_MEMX_ADDR;
  localparam int MY = DATA_WIDTH_MEMY_ADDR;
  localparam int MZ = DATA_WIDTH_MEMZ_ADDR;
  localparam int ZW = DATA_WIDTH_DATAZ;
  localparam int AW = 2 * DW + MX + 1;
  localparam int SW = (MX > MY ? MX : MY) + 2;
  localparam int KW = SW > MZ + 1 ? SW : MZ + 1;
  localparam logic [KW-1:0] K1 = KW'(1);
  typedef enum logic [2:0] {IDLE, SETUP, ADDR, MAC, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] sx_q, sx_d, sy_q, sy_d, k_q, k_d, i_q, i_d;
  logic sm_q, sm_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [MX-1:0] memX_addr_q, memX_addr_d;
  logic [MY-1:0] memY_addr_q, memY_addr_d;
  logic [MZ-1:0] memZ_addr_q, memZ_addr_d;
  logic [ZW-1:0] dataZ_q, dataZ_d;
  logic writeZ_q, writeZ_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [KW-1:0] n_in, n_q, i_lo, i_hi;
  logic bad_req, ovf_s, ovf_u;
  logic signed [2*DW-1:0] prod_s;
  logic [2*DW-1:0] prod_u;
  logic [AW-1:0] prod, acc_sum;
  logic [ZW-1:0] sat_s, res;
  assign memX_addr = memX_addr_q;
  assign memY_addr = memY_addr_q;
  assign memZ_addr = memZ_addr_q;
  assign dataZ     = dataZ_q;
  assign writeZ    = writeZ_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  always_comb begin
    n_in    = KW'(sizeX) + KW'(sizeY) - K1;
    bad_req = sizeX == '0 || sizeY == '0 || n_in > (K1 << MZ);
    n_q     = sx_q + sy_q - K1;
    // contributing X indices for output k: [max(0,k-sizeY+1), min(k,sizeX-1)]
    i_lo    = (k_q + K1 > sy_q) ? k_q + K1 - sy_q : '0;
    i_hi    = (k_q < sx_q - K1) ? k_q : sx_q - K1;
    prod_s  = $signed(dataX) * $signed(dataY);
    prod_u  = dataX * dataY;
    prod    = sm_q ? {{(AW-2*DW){prod_s[2*DW-1]}}, prod_s} : {{(AW-2*DW){1'b0}}, prod_u};
    acc_sum = acc_q + prod;
    // signed overflow: bits above the result sign bit disagree with the accumulator sign
    ovf_s   = acc_sum[AW-1:ZW-1] != {(AW-ZW+1){acc_sum[AW-1]}};
    ovf_u   = |acc_sum[AW-1:ZW];
    sat_s   = acc_sum[AW-1] ? {1'b1, {(ZW-1){1'b0}}} : {1'b0, {(ZW-1){1'b1}}};
    res     = SATURATE == 0 ? acc_sum[ZW-1:0] :
              sm_q ? (ovf_s ? sat_s : acc_sum[ZW-1:0]) : (ovf_u ? '1 : acc_sum[ZW-1:0]);
    state_d     = state_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    sm_d        = sm_q;
    k_d         = k_q;
    i_d         = i_q;
    acc_d       = acc_q;
    memX_addr_d = memX_addr_q;
    memY_addr_d = memY_addr_q;
    memZ_addr_d = memZ_addr_q;
    dataZ_d     = dataZ_q;
    writeZ_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    case (state_q)
      IDLE: if (start) begin
        if (bad_req) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          sx_d    = KW'(sizeX);
          sy_d    = KW'(sizeY);
          sm_d    = signed_mode;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        acc_d       = '0;
        i_d         = i_lo;
        memX_addr_d = MX'(i_lo);
        memY_addr_d = MY'(k_q - i_lo);
        state_d     = ADDR;
      end
      ADDR: state_d = MAC;
      MAC: begin
        acc_d = acc_sum;
        if (i_q == i_hi) begin
          writeZ_d    = 1'b1;
          memZ_addr_d = MZ'(k_q);
          dataZ_d     = res;
          state_d     = WRITE;
        end else begin
          i_d         = i_q + K1;
          memX_addr_d = MX'(i_q + K1);
          memY_addr_d = MY'(k_q - i_q - K1);
          state_d     = ADDR;
        end
      end
      WRITE: if (k_q == n_q - K1) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = 1'b0;
        state_d = DONE;
      end else begin
        k_d     = k_q + K1;
        state_d = SETUP;
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      sx_q        <= '0;
      sy_q        <= '0;
      sm_q        <= 1'b0;
      k_q         <= '0;
      i_q         <= '0;
      acc_q       <= '0;
      memX_addr_q <= '0;
      memY_addr_q <= '0;
      memZ_addr_q <= '0;
      dataZ_q     <= '0;
      writeZ_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      sm_q        <= sm_d;
      k_q         <= k_d;
      i_q         <= i_d;
      acc_q       <= acc_d;
      memX_addr_q <= memX_addr_d;
      memY_addr_q <= memY_addr_d;
      memZ_addr_q <= memZ_addr_d;
      dataZ_q     <= dataZ_d;
      writeZ_q    <= writeZ_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_convolution_processor_param.sv
// tb_convolution_processor_param: truncating (Z addr 6) and saturating (Z addr 5) instances driven in parallel against a convolution model.
module tb_convolution_processor_param;
  logic clk = 0, rstn = 0, start = 0, signed_mode = 0;
  logic [5:0] size_x = 0, size_y = 0;
  logic [7:0] mx [32], my [32];
  logic [7:0] dx0, dy0, dx1, dy1;
  logic [4:0] ax0, ay0, ax1, ay1, az1;
  logic [5:0] az0;
  logic [15:0] z0, z1;
  logic wz0, wz1, busy0, busy1, done0, done1, err0, err1;
  int total = 0, bad = 0;
  logic [15:0] zd [2][64];
  logic [5:0] za [2][64];
  int nw [2], bc [2], dt [2], dc [2], max_ax;
  logic er [2];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    dx0 <= mx[ax0]; dy0 <= my[ay0];
    dx1 <= mx[ax1]; dy1 <= my[ay1];
  end
  convolution_processor_param #(.DATA_WIDTH_MEMZ_ADDR(6), .SATURATE(0)) dut0 (
    .clk(clk), .rstn(rstn), .start(start), .signed_mode(signed_mode), .sizeX(size_x), .sizeY(size_y),
    .dataX(dx0), .dataY(dy0), .memX_addr(ax0), .memY_addr(ay0), .memZ_addr(az0), .dataZ(z0),
    .writeZ(wz0), .busy(busy0), .done(done0), .err(err0));
  convolution_processor_param #(.DATA_WIDTH_MEMZ_ADDR(5), .SATURATE(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start), .signed_mode(signed_mode), .sizeX(size_x), .sizeY(size_y),
    .dataX(dx1), .dataY(dy1), .memX_addr(ax1), .memY_addr(ay1), .memZ_addr(az1), .dataZ(z1),
    .writeZ(wz1), .busy(busy1), .done(done1), .err(err1));
  function automatic int zmodel(int k, int sx, int sy, bit sm, bit sat);
    int s = 0;
    for (int i = 0; i < sx; i++)
      if (k - i >= 0 && k - i < sy)
        s += sm ? int'($signed(mx[i])) * int'($signed(my[k-i])) : int'(mx[i]) * int'(my[k-i]);
    if (sat) s = sm ? (s > 32767 ? 32767 : s < -32768 ? -32768 : s) : (s > 65535 ? 65535 : s);
    return s & 'hFFFF;
  endfunction
  task automatic rec(input int d, input logic w, input logic [5:0] a, input logic [15:0] v,
                     input logic b, input logic dn, input logic e, input int t);
    if (w) begin
      if (nw[d] < 64) begin za[d][nw[d]] = a; zd[d][nw[d]] = v; end
      nw[d]++;
    end
    if (b) bc[d]++;
    if (dn) begin
      if (dt[d] < 0) begin dt[d] = t; er[d] = e; end
      dc[d]++;
    end
  endtask
  task automatic go(input int sx, input int sy, input bit sm);
    for (int d = 0; d < 2; d++) begin nw[d] = 0; bc[d] = 0; dt[d] = -1; dc[d] = 0; er[d] = 0; end
    max_ax = 0;
    @(negedge clk);
    size_x = 6'(sx); size_y = 6'(sy); signed_mode = sm; start = 1;
    for (int t = 0; t < 5000 && (dt[0] < 0 || dt[1] < 0); t++) begin
      @(negedge clk);
      rec(0, wz0, az0, z0, busy0, done0, err0, t);
      rec(1, wz1, {1'b0, az1}, z1, busy1, done1, err1, t);
      if (int'(ax0) > max_ax) max_ax = int'(ax0);
      start = busy0 & busy1 & 1'($urandom);
      size_x = 6'($urandom); size_y = 6'($urandom); signed_mode = 1'($urandom);
    end
    start = 0;
    @(negedge clk);
    rec(0, wz0, az0, z0, busy0, done0, err0, 99999);
    rec(1, wz1, {1'b0, az1}, z1, busy1, done1, err1, 99999);
  endtask
  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({busy0, done0, err0, wz0, ax0, ay0, az0, z0} !== '0) begin
      bad++; $display("FAIL reset dut0 got=%h want=0", {busy0, done0, err0, wz0, ax0, ay0, az0, z0});
    end
    total++;
    if ({busy1, done1, err1, wz1, ax1, ay1, az1, z1} !== '0) begin
      bad++; $display("FAIL reset dut1 got=%h want=0", {busy1, done1, err1, wz1, ax1, ay1, az1, z1});
    end
    rstn = 1;
  endtask
  task automatic test_basic(input string nm);
    logic [15:0] ev [4] = '{16'd4, 16'd13, 16'd22, 16'd15};
    mx[0] = 1; mx[1] = 2; mx[2] = 3; my[0] = 4; my[1] = 5;
    go(3, 2, 0);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (nw[d] !== 4 || bc[d] !== 20 || dt[d] !== 20 || er[d] !== 0 || dc[d] !== 1) begin
        bad++; $display("FAIL %s dut%0d writes/busy/done_t/err/dones got=%0d/%0d/%0d/%0b/%0d want=4/20/20/0/1",
                        nm, d, nw[d], bc[d], dt[d], er[d], dc[d]);
      end
      for (int j = 0; j < 4 && j < nw[d]; j++) begin
        total++;
        if (zd[d][j] !== ev[j] || za[d][j] !== 6'(j)) begin
          bad++; $display("FAIL %s dut%0d Z[%0d] got=%h@%0d want=%h@%0d", nm, d, j, zd[d][j], za[d][j], ev[j], j);
        end
      end
    end
  endtask
  task automatic test_signed;
    logic [15:0] ev [2][2] = '{'{16'h0080, 16'hFF81}, '{16'h7F80, 16'h7E81}};
    mx[0] = 8'hFF; my[0] = 8'h80; my[1] = 8'h7F;
    for (int m = 0; m < 2; m++) begin
      go(1, 2, m == 0);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (nw[d] !== 2 || bc[d] !== 8 || dt[d] !== 8) begin
          bad++; $display("FAIL signed%0d dut%0d writes/busy/done_t got=%0d/%0d/%0d want=2/8/8", m, d, nw[d], bc[d], dt[d]);
        end
        for (int j = 0; j < 2 && j < nw[d]; j++) begin
          total++;
          if (zd[d][j] !== ev[m][j]) begin
            bad++; $display("FAIL signed%0d dut%0d Z[%0d] got=%h want=%h", m, d, j, zd[d][j], ev[m][j]);
          end
        end
      end
    end
  endtask
  task automatic test_saturation;
    logic [15:0] ev [2][3] = '{'{16'hFE01, 16'hFC02, 16'hFE01}, '{16'hFE01, 16'hFFFF, 16'hFE01}};
    mx[0] = 255; mx[1] = 255; my[0] = 255; my[1] = 255;
    go(2, 2, 0);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (nw[d] !== 3) begin bad++; $display("FAIL sat dut%0d writes got=%0d want=3", d, nw[d]); end
      for (int j = 0; j < 3 && j < nw[d]; j++) begin
        total++;
        if (zd[d][j] !== ev[d][j]) begin
          bad++; $display("FAIL sat dut%0d Z[%0d] got=%h want=%h", d, j, zd[d][j], ev[d][j]);
        end
      end
    end
  endtask
  task automatic test_errors;
    int cs [4][3] = '{'{3, 0, 0}, '{0, 4, 1}, '{32, 32, 0}, '{17, 17, 1}};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 32; i++) begin mx[i] = 8'($urandom); my[i] = 8'($urandom); end
      go(cs[c][0], cs[c][1], cs[c][2] != 0);
      for (int d = 0; d < 2; d++) begin
        bit ee = c < 2 || d == 1;
        int ne = ee ? 0 : cs[c][0] + cs[c][1] - 1;
        total++;
        if (er[d] !== ee || nw[d] !== ne || dt[d] !== bc[d] || dc[d] !== 1 || (ee && bc[d] !== 0)) begin
          bad++; $display("FAIL err%0d dut%0d err/writes/busy/done_t/dones got=%0b/%0d/%0d/%0d/%0d want=%0b/%0d/busy=done_t/1",
                          c, d, er[d], nw[d], bc[d], dt[d], dc[d], ee, ne);
        end
        for (int j = 0; j < ne && j < nw[d]; j++) begin
          total++;
          if (zd[d][j] !== 16'(zmodel(j, cs[c][0], cs[c][1], cs[c][2] != 0, d == 1)) || za[d][j] !== 6'(j)) begin
            bad++; $display("FAIL err%0d dut%0d Z[%0d] got=%h@%0d want=%h@%0d", c, d, j, zd[d][j], za[d][j],
                            16'(zmodel(j, cs[c][0], cs[c][1], cs[c][2] != 0, d == 1)), j);
          end
        end
      end
      if (c == 2) begin
        total++;
        if (max_ax !== 31) begin bad++; $display("FAIL max_addr got=%0d want=31", max_ax); end
      end
    end
  endtask
  task automatic test_minimal;
    mx[0] = 7; my[0] = 6;
    go(1, 1, 0);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (nw[d] !== 1 || zd[d][0] !== 16'd42 || za[d][0] !== 0 || bc[d] !== 4 || dt[d] !== 4) begin
        bad++; $display("FAIL minimal dut%0d writes/Z/busy/done_t got=%0d/%0d/%0d/%0d want=1/42/4/4", d, nw[d], zd[d][0], bc[d], dt[d]);
      end
    end
  endtask
  task automatic test_random;
    for (int r = 0; r < 12; r++) begin
      int sx = $urandom_range(1, r < 8 ? 8 : 20);
      int sy = $urandom_range(1, r < 8 ? 8 : 20);
      bit sm = 1'($urandom);
      for (int i = 0; i < 32; i++) begin mx[i] = 8'($urandom); my[i] = 8'($urandom); end
      go(sx, sy, sm);
      for (int d = 0; d < 2; d++) begin
        bit ee = sx + sy - 1 > (d == 1 ? 32 : 64);
        int ne = ee ? 0 : sx + sy - 1;
        int be = ee ? 0 : 2 * ne + 2 * sx * sy;
        total++;
        if (er[d] !== ee || nw[d] !== ne || bc[d] !== be || dt[d] !== be || dc[d] !== 1) begin
          bad++; $display("FAIL rnd%0d dut%0d err/writes/busy/done_t/dones got=%0b/%0d/%0d/%0d/%0d want=%0b/%0d/%0d/%0d/1",
                          r, d, er[d], nw[d], bc[d], dt[d], dc[d], ee, ne, be, be);
        end
        for (int j = 0; j < ne && j < nw[d]; j++) begin
          total++;
          if (zd[d][j] !== 16'(zmodel(j, sx, sy, sm, d == 1)) || za[d][j] !== 6'(j)) begin
            bad++; $display("FAIL rnd%0d dut%0d Z[%0d] got=%h@%0d want=%h@%0d", r, d, j, zd[d][j], za[d][j],
                            16'(zmodel(j, sx, sy, sm, d == 1)), j);
          end
        end
      end
    end
  endtask
  task automatic test_reset_midrun;
    int seen = 0, extra = 0;
    mx[0] = 1; mx[1] = 2; mx[2] = 3; my[0] = 4; my[1] = 5;
    @(negedge clk);
    size_x = 3; size_y = 2; signed_mode = 0; start = 1;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      start = 0;
      seen = wz0;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL midrun first write got=none want=seen"); end
    repeat (3) @(negedge clk);
    rstn = 0;
    #1;
    total++;
    if ({busy0, done0, err0, wz0, ax0, ay0, az0, z0, busy1, done1, err1, wz1, ax1, ay1, az1, z1} !== '0) begin
      bad++; $display("FAIL midrun outputs got=%h want=0", {busy0, done0, err0, wz0, ax0, ay0, az0, z0});
    end
    repeat (6) begin @(negedge clk); if (wz0 | wz1 | busy0 | busy1) extra++; end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL midrun activity got=%0d want=0", extra); end
    rstn = 1;
    test_basic("restart");
  endtask
  initial begin
    test_reset;
    test_basic("basic");
    test_signed;
    test_saturation;
    test_errors;
    test_minimal;
    test_random;
    test_reset_midrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
